// File: rtl/tone_lut_loader_if.sv
// Tone-curve entry stream: start pulse plus valid/ready entry handshake.
interface tone_lut_loader_if #(
    parameter int unsigned LUT_MAP_WTH = 13
) ();
    logic                   i_lut_start;
    logic                   i_lut_vld;
    logic [LUT_MAP_WTH-1:0] i_lut_data;
    logic                   o_lut_rdy;

    // Curve source (software / sequencer side)
    modport master (
        output i_lut_start,
        output i_lut_vld,
        output i_lut_data,
        input  o_lut_rdy
    );

    // Curve loader side
    modport slave (
        input  i_lut_start,
        input  i_lut_vld,
        input  i_lut_data,
        output o_lut_rdy
    );
endinterface

// File: rtl/tone_lut_loader.sv
// Tone-curve loader: collects LUT_MAP_NUM y-values into a shadow bank, checks
// monotonicity, and swaps the shadow into the active bank only at a frame start
// or on an explicit immediate commit, so the tone mapper never sees a mid-frame change.
module tone_lut_loader #(
    parameter int unsigned LUT_MAP_WTH = 13,
    parameter int unsigned LUT_MAP_NUM = 25,
    parameter int unsigned IDX_WTH     = 5,
    parameter logic [LUT_MAP_WTH*LUT_MAP_NUM-1:0] DEF_LUT = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    tone_lut_loader_if.slave                   lut_if,
    input  logic                               i_vstr,
    input  logic                               i_cmt_imm,
    output logic [LUT_MAP_WTH*LUT_MAP_NUM-1:0] o_tone_y_data,
    output logic [IDX_WTH-1:0]                 o_load_cnt,
    output logic                               o_pend,
    output logic                               o_err_mono,
    output logic                               o_cmt_done,
    output logic                               o_cmt_drop
);

    localparam logic [IDX_WTH-1:0] CNT_LAST = IDX_WTH'(LUT_MAP_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PEND
    } state_t;

    state_t                               state;
    logic [LUT_MAP_WTH-1:0]               shadow [LUT_MAP_NUM];
    logic [LUT_MAP_WTH*LUT_MAP_NUM-1:0]   shadow_flat;
    logic [LUT_MAP_WTH*LUT_MAP_NUM-1:0]   active;
    logic [LUT_MAP_WTH-1:0]               prev_y;
    logic [IDX_WTH-1:0]                   cnt;
    logic                                 err;
    logic                                 rdy;
    logic                                 pend;
    logic                                 cmt_done;
    logic                                 cmt_drop;
    logic                                 cmt_evt;
    logic                                 accept;

    assign cmt_evt = i_vstr | i_cmt_imm;
    assign accept  = lut_if.i_lut_vld & rdy;

    // Pack the shadow bank into the same layout as the output bus
    always_comb begin
        shadow_flat = '0;
        for (int unsigned k = 0; k < LUT_MAP_NUM; k++) begin
            shadow_flat[k*LUT_MAP_WTH +: LUT_MAP_WTH] = shadow[k];
        end
    end

    // Load/pending/commit state machine with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            shadow   <= '{default: '0};
            active   <= DEF_LUT;
            prev_y   <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            rdy      <= 1'b0;
            pend     <= 1'b0;
            cmt_done <= 1'b0;
            cmt_drop <= 1'b0;
        end else begin
            cmt_done <= 1'b0;
            cmt_drop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (lut_if.i_lut_start) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                        err   <= 1'b0;
                        rdy   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (lut_if.i_lut_start) begin
                        cnt <= '0;
                        err <= 1'b0;
                    end else if (accept) begin
                        for (int unsigned k = 0; k < LUT_MAP_NUM; k++) begin
                            if (cnt == IDX_WTH'(k)) begin
                                shadow[k] <= lut_if.i_lut_data;
                            end
                        end
                        // prev_y always equals shadow[cnt-1] once cnt>0, since every
                        // accepted entry is written to both and restarts clear cnt.
                        prev_y <= lut_if.i_lut_data;
                        if (cnt != '0 && lut_if.i_lut_data < prev_y) begin
                            err <= 1'b1;
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= S_PEND;
                            rdy   <= 1'b0;
                            pend  <= 1'b1;
                        end
                    end
                end
                S_PEND: begin
                    if (cmt_evt) begin
                        if (err) begin
                            cmt_drop <= 1'b1;
                        end else begin
                            active   <= shadow_flat;
                            cmt_done <= 1'b1;
                        end
                        state <= S_IDLE;
                        pend  <= 1'b0;
                    end
                    // A restart wins the next state, after any commit above is taken
                    if (lut_if.i_lut_start) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                        err   <= 1'b0;
                        rdy   <= 1'b1;
                        pend  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    rdy   <= 1'b0;
                    pend  <= 1'b0;
                end
            endcase
        end
    end

    assign lut_if.o_lut_rdy = rdy;
    assign o_tone_y_data    = active;
    assign o_load_cnt       = cnt;
    assign o_pend           = pend;
    assign o_err_mono       = err;
    assign o_cmt_done       = cmt_done;
    assign o_cmt_drop       = cmt_drop;

endmodule
